// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the MIPS-style pipeline front end: the fetch FSM
// state type, the bubble encoding, the default reset PC, the rs/rt field
// positions and small PC arithmetic helpers.
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    // Fetch FSM: issuing a request, waiting for its data, or holding a word
    // that arrived while the pipeline was stalled.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Register-specifier field positions inside an instruction word
    localparam int RS_HI = 32'sd25;
    localparam int RS_LO = 32'sd21;
    localparam int RT_HI = 32'sd20;
    localparam int RT_LO = 32'sd16;

    // Sequential PC; wraps modulo 2^32 so 32'hFFFF_FFFC steps to 0
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register: PC, PC+4, instruction word and valid flag.
// Priority: flush > load > write (bubble) > hold.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears to bubble)
//   i_flush        replace contents with a bubble (wins over everything)
//   i_load         capture i_pc / i_pc_plus4 / i_instr as a valid entry
//   i_write        register may change; without i_load this inserts a bubble
//   i_pc, i_pc_plus4, i_instr   entry being loaded
//   o_pc, o_pc_plus4, o_instr, o_valid   registered contents
// -----------------------------------------------------------------------------
module if_id_reg
    import mips_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic        i_write,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_instr;
    logic        r_valid;

    // Pipeline register update with flush/load/bubble/hold priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= 32'h0000_0000;
            r_pc_plus4 <= 32'h0000_0000;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_pc       <= 32'h0000_0000;
            r_pc_plus4 <= 32'h0000_0000;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
            r_instr    <= i_instr;
            r_valid    <= 1'b1;
        end else if (i_write) begin
            r_pc       <= 32'h0000_0000;
            r_pc_plus4 <= 32'h0000_0000;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_instr    = r_instr;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch stage and IF/ID register. Owns the PC, issues at most one
// outstanding instruction-memory read, honours PCWrite/IF_Write stalls and
// redirects on a taken branch resolved in ID.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   PCWrite           PC may advance or redirect this cycle
//   IF_Write          IF/ID register may change this cycle
//   br_taken          branch taken in ID (only acted on with PCWrite)
//   br_target         branch destination, bits [1:0] ignored
//   imem_req          fetch request valid (registered, high in FETCH)
//   imem_addr         fetch address (the PC, always word aligned)
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid       read data valid (ignored outside WAIT)
//   imem_rdata        instruction word
//   pc_ID, pc_plus4_ID, instr_ID, valid_ID   IF/ID contents
//   rs_IF, rt_IF      rs/rt fields of instr_ID for the hazard unit
// -----------------------------------------------------------------------------
module if_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCWrite,
    input  logic            IF_Write,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] pc_ID,
    output logic [PC_W-1:0] pc_plus4_ID,
    output logic [31:0]     instr_ID,
    output logic            valid_ID,
    output logic [4:0]      rs_IF,
    output logic [4:0]      rt_IF
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_drop;   // the in-flight word belongs to a squashed path
    logic [31:0]  r_skid;   // word that arrived while the pipe was stalled
    logic         r_req;

    logic         w_redirect;
    logic         w_advance;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic         w_load;
    logic [31:0]  w_load_instr;
    logic         w_unused_br_lsb;

    assign w_redirect      = br_taken & PCWrite;
    assign w_advance       = PCWrite & IF_Write;
    assign w_target        = word_align(br_target);
    assign w_pc_plus4      = pc_plus4(r_pc);
    assign w_unused_br_lsb = &{1'b0, br_target[1:0]};

    // Decide whether a fetched word enters IF/ID this cycle and which one
    always_comb begin
        w_load       = 1'b0;
        w_load_instr = imem_rdata;
        case (r_state)
            FETCH: begin
                w_load       = 1'b0;
                w_load_instr = imem_rdata;
            end
            WAIT: begin
                w_load       = imem_rvalid & ~r_drop & w_advance & ~w_redirect;
                w_load_instr = imem_rdata;
            end
            HOLD: begin
                w_load       = w_advance & ~w_redirect;
                w_load_instr = r_skid;
            end
            default: begin
                w_load       = 1'b0;
                w_load_instr = imem_rdata;
            end
        endcase
    end

    // Fetch FSM, PC, drop flag, skid buffer and registered request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
            r_skid  <= NOP_INSTR;
            r_req   <= 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        // An accepted request carries the old PC: its data must be dropped
                        if (imem_ready) begin
                            r_drop  <= 1'b1;
                            r_state <= WAIT;
                            r_req   <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_drop <= 1'b0;
                        if (w_redirect) begin
                            r_pc <= w_target;
                        end else if (!r_drop && w_advance) begin
                            r_pc <= w_pc_plus4;
                        end
                        if (r_drop || w_redirect || w_advance) begin
                            r_state <= FETCH;
                            r_req   <= 1'b1;
                        end else begin
                            r_skid  <= imem_rdata;
                            r_state <= HOLD;
                        end
                    end else if (w_redirect) begin
                        r_pc   <= w_target;
                        r_drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_skid  <= NOP_INSTR;
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end else if (w_advance) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FETCH;
                    r_drop  <= 1'b0;
                    r_req   <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (w_redirect),
        .i_load     (w_load),
        .i_write    (IF_Write),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_plus4),
        .i_instr    (w_load_instr),
        .o_pc       (pc_ID),
        .o_pc_plus4 (pc_plus4_ID),
        .o_instr    (instr_ID),
        .o_valid    (valid_ID)
    );

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign rs_IF     = instr_ID[RS_HI:RS_LO];
    assign rt_IF     = instr_ID[RT_HI:RT_LO];

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (PC, request in flight, stale flag, parked word) predicts
// the request and IF/ID outputs every cycle; a small memory model answers
// accepted requests after a configurable latency.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWrite, IF_Write, br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_ID, pc_plus4_ID, instr_ID;
    logic        valid_ID;
    logic [4:0]  rs_IF, rt_IF;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_Write(IF_Write),
        .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_ID(pc_ID), .pc_plus4_ID(pc_plus4_ID), .instr_ID(instr_ID),
        .valid_ID(valid_ID), .rs_IF(rs_IF), .rt_IF(rt_IF)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_word, m_pc_id, m_pc4_id, m_instr_id;
    bit          m_inflight, m_stale, m_have, m_valid_id;

    task automatic model_bubble();
        m_pc_id = 32'h0; m_pc4_id = 32'h0; m_instr_id = 32'h0; m_valid_id = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_word = 32'h0;
        m_inflight = 1'b0; m_stale = 1'b0; m_have = 1'b0;
        model_bubble();
    endtask

    // One clock edge worth of behaviour, from the inputs present before it
    task automatic model_step();
        bit redirect, adv, requesting, arrives;
        redirect   = br_taken & PCWrite;
        adv        = PCWrite & IF_Write;
        requesting = !m_inflight && !m_have;
        arrives    = m_inflight && imem_rvalid;
        if (redirect) begin
            model_bubble();
            if (requesting) begin
                if (imem_ready) begin m_inflight = 1'b1; m_stale = 1'b1; end
            end else if (m_inflight) begin
                if (arrives) begin m_inflight = 1'b0; m_stale = 1'b0; end
                else m_stale = 1'b1;
            end else begin
                m_have = 1'b0;
            end
            m_pc = {br_target[31:2], 2'b00};
        end else begin
            if (requesting) begin
                if (imem_ready) m_inflight = 1'b1;
            end else if (arrives) begin
                m_inflight = 1'b0;
                if (m_stale) m_stale = 1'b0;
                else begin m_have = 1'b1; m_word = imem_rdata; end
            end
            if (m_have && adv) begin
                m_pc_id = m_pc; m_pc4_id = m_pc + 32'd4;
                m_instr_id = m_word; m_valid_id = 1'b1;
                m_pc = m_pc + 32'd4;
                m_have = 1'b0;
            end else if (IF_Write) begin
                model_bubble();
            end
        end
    endtask

    task automatic compare_all();
        bit exp_req;
        exp_req = !m_inflight && !m_have;
        chk_eq("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk_eq("imem_addr", imem_addr, m_pc);
        chk_eq("pc_ID", pc_ID, m_pc_id);
        chk_eq("pc_plus4_ID", pc_plus4_ID, m_pc4_id);
        chk_eq("instr_ID", instr_ID, m_instr_id);
        chk_eq("valid_ID", 32'(valid_ID), 32'(m_valid_id));
        chk_eq("rs_IF", 32'(rs_IF), (m_instr_id >> 21) & 32'h1F);
        chk_eq("rt_IF", 32'(rt_IF), (m_instr_id >> 16) & 32'h1F);
    endtask

    // ---------------- memory model ----------------
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_a;
    int          lat_min = 1, lat_max = 1;
    bit          spur_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h8C01_0000;
        if (a == 32'h0000_3004) return 32'h0000_0000;
        return {a[15:0] ^ 16'h1357, a[31:16] ^ 16'h2468};
    endfunction

    // Advance one clock: model and memory react, outputs are compared after
    // the edge, then the next cycle's read data is presented at the negedge.
    task automatic tick();
        bit acc;
        logic [31:0] a;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        model_step();
        @(posedge clk);
        #1;
        if (acc) begin
            mem_busy = 1'b1;
            mem_cnt  = int'($urandom_range(lat_max, lat_min));
            mem_a    = a;
        end
        compare_all();
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_a);
                mem_busy    = 1'b0;
            end
        end else if (spur_en && ($urandom_range(3, 0) == 0)) begin
            imem_rvalid = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; PCWrite = 1'b1; IF_Write = 1'b1; br_taken = 1'b0;
        br_target = 32'h0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0; mem_a = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_eq("rst_valid_ID", 32'(valid_ID), 32'h0);
        chk_eq("rst_instr_ID", instr_ID, 32'h0);
        chk_eq("rst_pc_ID", pc_ID, 32'h0);
        chk_eq("rst_req", 32'(imem_req), 32'h1);
        chk_eq("rst_addr", imem_addr, 32'h0000_3000);
        rst_n = 1'b1;

        // Straight-line fetch, single-cycle memory
        tick(); tick();
        chk_eq("first_instr", instr_ID, 32'h8C01_0000);
        chk_eq("first_pc", pc_ID, 32'h0000_3000);
        chk_eq("first_rt", 32'(rt_IF), 32'h1);
        chk_eq("next_addr", imem_addr, 32'h0000_3004);

        // Stall while the next word returns
        PCWrite = 1'b0; IF_Write = 1'b0;
        repeat (4) tick();
        chk_eq("stall_req", 32'(imem_req), 32'h0);
        chk_eq("stall_instr", instr_ID, 32'h8C01_0000);
        chk_eq("stall_pc", pc_ID, 32'h0000_3000);
        PCWrite = 1'b1; IF_Write = 1'b1;
        tick();
        chk_eq("skid_pc", pc_ID, 32'h0000_3004);
        chk_eq("skid_valid", 32'(valid_ID), 32'h1);
        chk_eq("skid_next_addr", imem_addr, 32'h0000_3008);

        // Branch while waiting for data with no rvalid yet
        lat_min = 3; lat_max = 3;
        tick();
        br_taken = 1'b1; br_target = 32'h0000_3043;
        tick();
        br_taken = 1'b0;
        chk_eq("br_bubble_valid", 32'(valid_ID), 32'h0);
        chk_eq("br_bubble_instr", instr_ID, 32'h0);
        for (int i = 0; i < 6 && !imem_req; i++) tick();
        chk_eq("br_req_back", 32'(imem_req), 32'h1);
        chk_eq("br_addr", imem_addr, 32'h0000_3040);
        chk_eq("br_drop_valid", 32'(valid_ID), 32'h0);

        // Branch ignored while PCWrite is low, taken once it rises
        imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3100;
        PCWrite = 1'b0; IF_Write = 1'b0;
        tick();
        chk_eq("br_stalled_addr", imem_addr, 32'h0000_3040);
        PCWrite = 1'b1;
        tick();
        chk_eq("br_released_addr", imem_addr, 32'h0000_3100);

        // PC wrap through the top of the address space
        IF_Write = 1'b1; br_target = 32'hFFFF_FFFC;
        tick();
        br_taken = 1'b0; imem_ready = 1'b1; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8 && !valid_ID; i++) tick();
        chk_eq("wrap_pc", pc_ID, 32'hFFFF_FFFC);
        chk_eq("wrap_pc4", pc_plus4_ID, 32'h0);
        chk_eq("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of a read
        lat_min = 3; lat_max = 3; PCWrite = 1'b0; IF_Write = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_pc_ID", pc_ID, 32'h0);
        chk_eq("arst_pc4", pc_plus4_ID, 32'h0);
        chk_eq("arst_instr", instr_ID, 32'h0);
        chk_eq("arst_valid", 32'(valid_ID), 32'h0);
        chk_eq("arst_addr", imem_addr, 32'h0000_3000);
        model_reset();
        mem_busy = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        rst_n = 1'b1;
        PCWrite = 1'b1; IF_Write = 1'b1;
        compare_all();

        // Randomized traffic
        lat_min = 1; lat_max = 3; spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            PCWrite    = ($urandom_range(3, 0) != 0);
            IF_Write   = ($urandom_range(4, 0) != 0);
            br_taken   = ($urandom_range(7, 0) == 0);
            br_target  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                     : $urandom;
            imem_ready = ($urandom_range(2, 0) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
